// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: posted-write line FIFO between L2 and the cacheline adaptor with read forwarding and write coalescing
module l2_writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [255:0] mem_wdata,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         wb_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;
  state_t state, state_n;
  logic [DEPTH-1:0] valid;
  logic [26:0] tags [DEPTH];
  logic [255:0] lines [DEPTH];
  logic [AW-1:0] head, tail, hit_idx;
  logic [AW:0] count;
  logic hit, rd_hit, wr_hit, wr_alloc, drain_done, unused;
  assign unused = ^mem_address[4:0];
  assign wb_empty = count == '0;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && tags[i] == mem_address[31:5]) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
  end
  // a write stalled on a full buffer falls through to DRAIN and is retried in IDLE afterwards
  always_comb begin
    state_n = state;
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    wr_alloc = 1'b0;
    drain_done = state == DRAIN && pmem_resp;
    case (state)
      IDLE:
        if (mem_read) begin
          rd_hit = hit;
          state_n = hit ? RESP : READ;
        end else if (mem_write && (hit || count != FULL)) begin
          wr_hit = hit;
          wr_alloc = !hit;
          state_n = RESP;
        end else if (count != '0) state_n = DRAIN;
      READ:    state_n = pmem_resp ? RESP : READ;
      DRAIN:   state_n = pmem_resp ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      mem_resp <= 1'b0;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
      mem_rdata <= '0;
      pmem_address <= '0;
      pmem_wdata <= '0;
    end else begin
      state <= state_n;
      mem_resp <= state_n == RESP;
      pmem_read <= state_n == READ;
      pmem_write <= state_n == DRAIN;
      if (state == IDLE && state_n == READ) pmem_address <= {mem_address[31:5], 5'b0};
      if (state == IDLE && state_n == DRAIN) begin
        pmem_address <= {tags[head], 5'b0};
        pmem_wdata <= lines[head];
      end
      if (rd_hit) mem_rdata <= lines[hit_idx];
      if (state == READ && pmem_resp) mem_rdata <= pmem_rdata;
      if (wr_alloc) begin
        valid[tail] <= 1'b1;
        tail <= tail + 1'b1;
        count <= count + 1'b1;
      end
      if (drain_done) begin
        valid[head] <= 1'b0;
        head <= head + 1'b1;
        count <= count - 1'b1;
      end
    end
  // entry payload needs no reset: valid bits alone decide whether an entry is live
  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      tags[tail] <= mem_address[31:5];
      lines[tail] <= mem_wdata;
    end
    if (wr_hit) lines[hit_idx] <= mem_wdata;
  end
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: self-checking bench with vector table, directed corner sequences and random traffic against a flat-memory model
module tb_l2_writeback_buffer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] mem_address = '0, pmem_address;
  logic mem_read = 1'b0, mem_write = 1'b0, mem_resp, pmem_read, pmem_write, pmem_resp, wb_empty;
  logic [255:0] mem_wdata = '0, mem_rdata, pmem_wdata, pmem_rdata;

  l2_writeback_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {bit wr; logic [31:0] addr; logic [255:0] data;} op_t;
  typedef struct {bit wr; logic [31:0] addr; logic [255:0] wd; logic [255:0] exp_rd; int exp_lat;} vec_t;

  int n_checks = 0, n_fail = 0;
  bit after_resp = 1'b0;
  int rsp_lat = 0, rsp_cnt = 0, busy_cycles = 0, rd_cycles = 0;
  op_t ops[$];
  logic [255:0] bmem [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic logic [255:0] model_read(input logic [31:0] a);
    return ref_mem.exists(line_of(a)) ? ref_mem[line_of(a)] : pat(line_of(a));
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // adaptor model: answers each pmem request after rsp_lat extra cycles with a one-cycle pmem_resp
  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        pmem_resp = 1'b0;
        rsp_cnt = 0;
      end else if (pmem_resp) pmem_resp = 1'b0;
      else if (pmem_read || pmem_write) begin
        busy_cycles++;
        if (pmem_read) rd_cycles++;
        if (rsp_cnt >= rsp_lat) begin
          rsp_cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            bmem[pmem_address] = pmem_wdata;
            ops.push_back('{1'b1, pmem_address, pmem_wdata});
          end else begin
            pmem_rdata = bmem.exists(pmem_address) ? bmem[pmem_address] : pat(pmem_address);
            ops.push_back('{1'b0, pmem_address, pmem_rdata});
          end
        end else rsp_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    after_resp = 1'b0;
  endtask

  // latency is counted from the first IDLE cycle that can see the request
  task automatic l2_op(input bit wr, input logic [31:0] a, input logic [255:0] d,
                       output logic [255:0] rd, output int lat_o);
    int w;
    w = after_resp ? -1 : 0;
    mem_read = !wr;
    mem_write = wr;
    mem_address = a;
    mem_wdata = d;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_resp && w < 300);
    if (!mem_resp) begin
      n_checks++;
      n_fail++;
      $display("FAIL l2_op_timeout: addr %h got no mem_resp required one", a);
    end else if (wr) ref_mem[line_of(a)] = d;
    rd = mem_rdata;
    lat_o = w;
    mem_read = 1'b0;
    mem_write = 1'b0;
    after_resp = 1'b1;
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!wb_empty && w < 1000);
    check("wait_empty", wb_empty, 1);
    after_resp = 1'b0;
  endtask

  initial begin
    vec_t vt [11];
    logic [255:0] rd, exp, wd [10];
    int lt, s, bc0;
    vt[0]  = '{1'b1, 32'h1000, {8{32'hAAAA_0001}}, '0, 1};
    vt[1]  = '{1'b0, 32'h1010, '0, {8{32'hAAAA_0001}}, 1};
    vt[2]  = '{1'b1, 32'h1000, {8{32'hCCCC_0003}}, '0, 1};
    vt[3]  = '{1'b0, 32'h1000, '0, {8{32'hCCCC_0003}}, 1};
    vt[4]  = '{1'b1, 32'h2000, {8{32'hBBBB_0002}}, '0, 1};
    vt[5]  = '{1'b0, 32'h3000, '0, {8{32'h3000 ^ 32'h5A5A_C3C3}}, 4};
    vt[6]  = '{1'b1, 32'h4000, {8{32'hDDDD_0004}}, '0, 1};
    vt[7]  = '{1'b1, 32'h5000, {8{32'hEEEE_0005}}, '0, 1};
    vt[8]  = '{1'b1, 32'h6000, {8{32'hFFFF_0006}}, '0, 5};
    vt[9]  = '{1'b0, 32'h601F, '0, {8{32'hFFFF_0006}}, 1};
    vt[10] = '{1'b0, 32'h1000, '0, {8{32'hCCCC_0003}}, 4};

    repeat (3) @(negedge clk);
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_wb_empty", wb_empty, 1);
    reset_n = 1'b1;
    tick(2);

    rsp_lat = 2;
    for (int i = 0; i < 11; i++) begin
      l2_op(vt[i].wr, vt[i].addr, vt[i].wd, rd, lt);
      check($sformatf("vec%0d_latency", i), lt, vt[i].exp_lat);
      if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
    end
    wait_empty();

    s = rd_cycles;
    l2_op(1'b1, 32'h1000, {8{32'h1234_5678}}, rd, lt);
    check("posted_write_latency", lt, 1);
    l2_op(1'b0, 32'h1010, '0, rd, lt);
    check("forward_latency", lt, 1);
    check("forward_rdata", rd, {8{32'h1234_5678}});
    check("forward_no_pmem_read", rd_cycles, s);
    wait_empty();

    s = ops.size();
    l2_op(1'b1, 32'h2000, {8{32'hB0B0_B0B0}}, rd, lt);
    l2_op(1'b1, 32'h2000, {8{32'hC0C0_C0C0}}, rd, lt);
    check("coalesce_count", dut.count, 1);
    wait_empty();
    check("coalesce_one_write", ops.size(), s + 1);
    if (ops.size() > s) begin
      check("coalesce_addr", ops[s].addr, 32'h2000);
      check("coalesce_data", ops[s].data, {8{32'hC0C0_C0C0}});
    end

    rsp_lat = 5;
    s = ops.size();
    for (int i = 0; i < 4; i++) l2_op(1'b1, 32'(i * 32), {8{32'h0F00 + i}}, rd, lt);
    l2_op(1'b1, 32'h80, {8{32'h0F04}}, rd, lt);
    check("stall_latency", lt, 8);
    check("stall_one_drain_first", ops.size(), s + 1);
    if (ops.size() > s) check("stall_first_drain_addr", ops[s].addr, 32'h0);
    wait_empty();
    check("stall_drain_total", ops.size(), s + 5);
    for (int i = 1; i < 5; i++)
      if (ops.size() > s + i) check($sformatf("stall_order%0d", i), ops[s+i].addr, 32'(i * 32));

    rsp_lat = 2;
    s = ops.size();
    l2_op(1'b1, 32'h100, {8{32'h0100_0100}}, rd, lt);
    exp = model_read(32'h300);
    l2_op(1'b0, 32'h300, '0, rd, lt);
    check("prio_rdata", rd, exp);
    wait_empty();
    check("prio_op_count", ops.size(), s + 2);
    if (ops.size() > s + 1) begin
      check("prio_first_is_read", {ops[s].wr, ops[s].addr}, {1'b0, 32'h300});
      check("prio_then_write", {ops[s+1].wr, ops[s+1].addr}, {1'b1, 32'h100});
      check("prio_rdata_from_pmem", rd, ops[s].data);
    end

    rsp_lat = 1;
    s = ops.size();
    for (int i = 0; i < 10; i++) begin
      wd[i] = {8{32'hC0DE_0000 + i}};
      l2_op(1'b1, 32'hC000 + 32'(i * 32), wd[i], rd, lt);
    end
    wait_empty();
    check("wrap_write_count", ops.size(), s + 10);
    for (int i = 0; i < 10; i++)
      if (ops.size() > s + i) begin
        check($sformatf("wrap_addr%0d", i), ops[s+i].addr, 32'hC000 + 32'(i * 32));
        check($sformatf("wrap_data%0d", i), ops[s+i].data, wd[i]);
      end
    check("wrap_empty", wb_empty, 1);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      bit wr;
      a = 32'hA000 + 32'($urandom_range(0, 5) * 32) + 32'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      rsp_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
      exp = model_read(a);
      l2_op(wr, a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, rd, lt);
      if (!wr) check($sformatf("rand%0d_rdata", i), rd, exp);
    end
    wait_empty();
    foreach (ref_mem[k]) check($sformatf("final_mem_%h", k), bmem.exists(k) ? bmem[k] : pat(k), ref_mem[k]);

    rsp_lat = 10;
    l2_op(1'b1, 32'h7000, {8{32'h7777_7777}}, rd, lt);
    for (int w = 0; w < 20 && !pmem_write; w++) @(negedge clk);
    check("rst_drain_started", pmem_write, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_pmem_write", pmem_write, 0);
    check("rst_mid_wb_empty", wb_empty, 1);
    check("rst_mid_mem_resp", mem_resp, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    s = ops.size();
    bc0 = busy_cycles;
    tick(20);
    check("rst_no_pmem_activity", busy_cycles, bc0);
    check("rst_no_pmem_ops", ops.size(), s);
    check("rst_line_discarded", bmem.exists(32'h7000), 0);
    check("rst_after_wb_empty", wb_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_writeback_buffer.md
# l2_writeback_buffer

Posted-write buffer between the shared L2 cache and the cacheline adaptor. Absorbs L2 dirty-line writebacks into a small FIFO so that the L2 is released after one cycle, and forwards read misses to memory ahead of queued writebacks. Line reads that hit a buffered line are served from the buffer. Writes to a line that is already buffered are coalesced into the existing entry.

## Interface
Parameters:
- DEPTH, 4: number of 256-bit line entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_address  in  32  line address from L2; bits [4:0] are ignored.
- mem_read  in  1  L2 line read request; held until mem_resp.
- mem_write  in  1  L2 line writeback request; held until mem_resp.
- mem_wdata  in  256  writeback line data.
- mem_rdata  out  256  read line data; valid while mem_resp=1.
- mem_resp  out  1  single-cycle completion pulse to L2.
- pmem_address  out  32  line-aligned address to the cacheline adaptor ({tag,5'b0}).
- pmem_read  out  1  line read to the adaptor; held until pmem_resp.
- pmem_write  out  1  line write to the adaptor; held until pmem_resp.
- pmem_wdata  out  256  line write data.
- pmem_rdata  in  256  line read data; valid with pmem_resp.
- pmem_resp  in  1  adaptor completion pulse.
- wb_empty  out  1  high when no entries are valid.

## Operation
- Storage: DEPTH entries, each holding valid, tag[26:0] (= address[31:5]) and data[255:0]. Entries are kept as a circular FIFO with head/tail pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1.
- Lookup is combinational. An entry matches when it is valid and its tag equals mem_address[31:5]. Coalescing guarantees at most one matching entry.
- State machine: IDLE, READ, DRAIN, RESP.
- IDLE priority, highest first:
  1. mem_read with a match: register the entry data into mem_rdata, go to RESP.
  2. mem_read without a match: go to READ.
  3. mem_write with a match: overwrite that entry's data (count unchanged), go to RESP.
  4. mem_write without a match and count<DEPTH: write to the tail entry, advance tail, count+1, go to RESP.
  5. count>0 (this includes the case of a write stalled on a full buffer): go to DRAIN.
  6. Otherwise stay in IDLE.
- READ: pmem_read=1 and pmem_address={mem_address[31:5],5'b0} are registered outputs. On pmem_resp, capture pmem_rdata into mem_rdata and go to RESP.
- DRAIN: pmem_write=1, pmem_address={head tag,5'b0}, pmem_wdata=head data. On pmem_resp, clear the head valid bit, advance head, count-1, go to IDLE.
- RESP: mem_resp=1 for exactly one cycle, then go to IDLE. L2 must deassert its request or present a new one on the following cycle.
- mem_read and mem_write asserted together is illegal; if it happens, the read is served.
- Head and tail wrap from DEPTH-1 to 0.
- wb_empty = (count==0).

## Timing
- Reset (asynchronous, reset_n=0) returns:
  - state to IDLE;
  - head, tail and count to 0; all valid bits to 0;
  - mem_resp, pmem_read, pmem_write to 0;
  - mem_rdata, pmem_address, pmem_wdata to 0;
  - wb_empty to 1.
- Reset mid-transaction abandons any outstanding pmem operation and discards all buffered lines.
- Write accepted in IDLE at cycle N: mem_resp in cycle N+1.
- Read hit at cycle N: mem_resp in cycle N+1, with mem_rdata equal to the buffered (coalesced) data.
- Read miss at cycle N:
  - pmem_read is high from cycle N+1 until the pmem_resp cycle M, inclusive.
  - mem_resp and mem_rdata are valid in cycle M+1.
- Drain decided at cycle N: pmem_write is high from N+1 through the pmem_resp cycle M; the state is IDLE in M+1.
- Full with a non-matching write: no mem_resp until one drain completes. The write is accepted in the IDLE cycle after the drain, so mem_resp follows one cycle later.
- A read arriving while a DRAIN is in flight waits until the drain finishes. Reads are then served before any further drain.
- Worst-case upstream write latency with the buffer full: 2 cycles + one pmem write latency + 1 cycle.

## Test plan
- Reset: hold reset_n=0 during DRAIN with pmem_write=1. Required: pmem_write=0 immediately, wb_empty=1, and no pmem activity after release.
- Posted write then forward: write 0x1000 with data A. Required: mem_resp at N+1. Then read 0x1010 before any drain. Required: mem_resp with mem_rdata=A and pmem_read never asserted.
- Coalesce: write 0x2000 with B, then write 0x2000 with C. Required: count=1. After the drain, exactly one pmem_write to 0x2000 with C.
- Full stall: DEPTH=4; write 0x0, 0x20, 0x40, 0x60, then 0x80, with pmem_resp delayed 5 cycles. Required: no mem_resp for 0x80 until the write to 0x0 completes. After that, 0x80 is accepted, and draining proceeds in FIFO order 0x20, 0x40, 0x60, 0x80.
- Read-miss priority: buffer holds 0x100; read 0x300 arrives in IDLE. Required: pmem_read to 0x300 is issued before pmem_write to 0x100, and mem_rdata equals the pmem_rdata returned.
- Wrap-around: issue 10 writes and drains to distinct lines. Required: pmem_write order matches write order across the pointer wrap, and wb_empty=1 at the end.
